// File: rtl/count_ones_pkg.sv
// Shared constants and helpers for the count_ones population counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package count_ones_pkg;

  // Default input vector width in bits (multiple of 4, 4..64).
  localparam int DEFAULT_WIDTH = 16;

  // Width of a per-nibble count: a nibble holds 0..4 set bits.
  localparam int NIBBLE_CNT_W = 3;

  // Bits needed to represent 0..w inclusive, so an all-ones vector never wraps.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/count_ones_nibble_popcount.sv
// Counts the set bits of one 4-bit nibble; X/Z bits count as zero.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module nibble_popcount
  import count_ones_pkg::*;
(
  input  logic [3:0]              nib,
  output logic [NIBBLE_CNT_W-1:0] cnt
);

  // Only a definite 1 contributes; unknown bits are treated as 0.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 4; i++) begin
      if (nib[i] === 1'b1) begin
        cnt = cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_ones.sv
// Two-stage pipelined population count of a WIDTH-bit vector.
// Latency: vec taken at edge N appears on count with out_valid after edge N+1.
// Backpressure: none; one result per cycle, each shown for exactly one cycle.
module count_ones
  import count_ones_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] vec,
  output logic             out_valid,
  output logic [CNT_W-1:0] count
);

  localparam int NIB    = WIDTH / 4;
  // Tree leaves rounded up to a power of two; unused leaves are tied to zero.
  localparam int LEAVES = 1 << $clog2(NIB);

  logic [NIBBLE_CNT_W-1:0] nib_cnt [NIB];
  logic [NIBBLE_CNT_W-1:0] nib_q   [NIB];
  logic                    vld_s1;
  logic [CNT_W-1:0]        tree    [1:2*LEAVES-1];
  logic [CNT_W-1:0]        sum;

  for (genvar g = 0; g < NIB; g++) begin : g_nib
    nibble_popcount u_pop (
      .nib (vec[4*g +: 4]),
      .cnt (nib_cnt[g])
    );
  end

  // Stage 1: capture per-nibble counts for qualified vectors; valid shifts every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_s1 <= 1'b0;
      for (int i = 0; i < NIB; i++) begin
        nib_q[i] <= '0;
      end
    end else begin
      vld_s1 <= in_valid;
      if (in_valid) begin
        nib_q <= nib_cnt;
      end
    end
  end

  // Heap-ordered binary adder tree; every node is CNT_W wide so no carry is dropped.
  always_comb begin
    tree = '{default: '0};
    for (int i = 0; i < NIB; i++) begin
      tree[LEAVES+i] = CNT_W'(nib_q[i]);
    end
    for (int i = LEAVES - 1; i >= 1; i--) begin
      tree[i] = tree[2*i] + tree[2*i+1];
    end
    sum = tree[1];
  end

  // Stage 2: publish the sum; count holds its last value through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      count     <= '0;
    end else begin
      out_valid <= vld_s1;
      if (vld_s1) begin
        count <= sum;
      end
    end
  end

endmodule

// File: tb/tb_count_ones.sv
// Directed and random checks of the count_ones pipeline at WIDTH=16.
// Latency: results are expected two input slots after they are driven.
// Backpressure: none; outputs are sampled 1ns after each rising edge.
module tb_count_ones;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] vec;
  logic        out_valid;
  logic [4:0]  count;

  int checks   = 0;
  int failures = 0;

  count_ones #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .vec       (vec),
    .out_valid (out_valid),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one input slot, then step to 1ns past the edge that samples it.
  task automatic drive(input logic [15:0] v, input logic vld);
    vec      = v;
    in_valid = vld;
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_pop(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      if (v[i] === 1'b1) n++;
    end
    return n;
  endfunction

  initial begin
    logic [15:0] rv;
    logic        rvld;
    logic        last_vld;
    int          last_cnt;
    int          held_cnt;

    // Asynchronous reset, before any clock edge.
    rst_n    = 1'b1;
    in_valid = 1'b0;
    vec      = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_count", 32'(count), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Zero vector: nothing at one edge, result at the next, then gone.
    drive(16'h0000, 1'b1);
    check("zero_early_valid", 32'(out_valid), 0);
    drive(16'h0000, 1'b0);
    check("zero_valid", 32'(out_valid), 1);
    check("zero_count", 32'(count), 0);
    drive(16'h0000, 1'b0);
    check("zero_one_cycle", 32'(out_valid), 0);

    // All-ones, sparse and alternating patterns back to back.
    drive(16'hFFFF, 1'b1);
    drive(16'h8001, 1'b1);
    check("ffff_valid", 32'(out_valid), 1);
    check("ffff_count", 32'(count), 16);
    drive(16'hAAAA, 1'b1);
    check("8001_count", 32'(count), 2);
    drive(16'h0000, 1'b0);
    check("aaaa_valid", 32'(out_valid), 1);
    check("aaaa_count", 32'(count), 8);
    drive(16'h0000, 1'b0);
    check("idle_valid", 32'(out_valid), 0);
    check("idle_hold", 32'(count), 8);

    // Consecutive results keep out_valid high and stay in order.
    drive(16'h0001, 1'b1);
    drive(16'h0003, 1'b1);
    check("b2b_1_valid", 32'(out_valid), 1);
    check("b2b_1_count", 32'(count), 1);
    drive(16'h0007, 1'b1);
    check("b2b_2_valid", 32'(out_valid), 1);
    check("b2b_2_count", 32'(count), 2);
    drive(16'h0000, 1'b0);
    check("b2b_3_valid", 32'(out_valid), 1);
    check("b2b_3_count", 32'(count), 3);
    drive(16'h0000, 1'b0);

    // Bubble in the middle: unqualified FFFF must not appear.
    drive(16'h00FF, 1'b1);
    drive(16'hFFFF, 1'b0);
    check("bub_a_valid", 32'(out_valid), 1);
    check("bub_a_count", 32'(count), 8);
    drive(16'h000F, 1'b1);
    check("bub_gap_valid", 32'(out_valid), 0);
    check("bub_gap_hold", 32'(count), 8);
    drive(16'h0000, 1'b0);
    check("bub_b_valid", 32'(out_valid), 1);
    check("bub_b_count", 32'(count), 4);
    drive(16'h0000, 1'b0);

    // Reset while a result is in flight discards it.
    drive(16'hFFFF, 1'b1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_count", 32'(count), 0);
    @(posedge clk); #1;
    check("midrst_held_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    drive(16'h0000, 1'b0);
    check("postrst_valid_a", 32'(out_valid), 0);
    check("postrst_count_a", 32'(count), 0);
    drive(16'h0000, 1'b0);
    check("postrst_valid_b", 32'(out_valid), 0);
    check("postrst_count_b", 32'(count), 0);

    // First edge after release accepts input.
    drive(16'h0101, 1'b1);
    drive(16'h0000, 1'b0);
    check("first_after_rst_valid", 32'(out_valid), 1);
    check("first_after_rst_count", 32'(count), 2);
    drive(16'h0000, 1'b0);

    // Random vectors, per-bit P(1)=6/16, with occasional bubbles.
    last_vld = 1'b0;
    last_cnt = 0;
    held_cnt = 2;
    for (int k = 0; k < 20000; k++) begin
      for (int b = 0; b < 16; b++) begin
        rv[b] = ($urandom_range(0, 15) < 6);
      end
      rvld = ($urandom_range(0, 7) != 0);
      drive(rv, rvld);
      if (last_vld) held_cnt = last_cnt;
      check("rand_valid", 32'(out_valid), 32'(last_vld));
      check("rand_count", 32'(count), 32'(held_cnt));
      last_vld = rvld;
      last_cnt = ref_pop(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_ones.md
COUNT_ONES -- requirements
Module: count_ones

Interface
REQ-001 Parameter WIDTH, default 16, input vector width in bits; supported values are multiples of 4 from 4 to 64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1) (5 for WIDTH=16), count output width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  qualifies vec for the current cycle.
REQ-006 Port vec  input  WIDTH  vector whose set bits are counted.
REQ-007 Port out_valid  output  1  count holds a valid result this cycle.
REQ-008 Port count  output  CNT_W  number of bits equal to 1'b1 in the qualified vec.
REQ-009 The block shall use one clock (clk) and an asynchronous active-low reset (rst_n); no other clock or reset shall exist.

Function
REQ-010 count shall equal the number of bit positions i, 0..WIDTH-1, where vec[i] is exactly 1'b1; X/Z bits shall count as 0.
REQ-011 Range: 0..WIDTH; all-ones input shall yield WIDTH (16 -> 5'b10000) without overflow or wrap.
REQ-012 The pipeline has two stages. Stage 1 registers per-nibble counts (3 bits each, 0..4) and a valid bit. Stage 2 registers the adder-tree sum of the nibble counts into count.
REQ-013 Latency: vec sampled with in_valid=1 at edge N shall appear on count with out_valid=1 after edge N+1, stable until edge N+2.
REQ-014 Throughput: one result per cycle; back-to-back in_valid results emerge back-to-back in input order.
REQ-015 No backpressure: out_valid is not acknowledged; each result is present for exactly one cycle.
REQ-016 When in_valid=0, the corresponding output cycle shall have out_valid=0 and count shall hold its previous value.
REQ-017 The adder tree shall size intermediate sums so no carry is lost at any level.
REQ-018 The block has no state machine; the valid bits form a 2-deep shift chain.

Reset
REQ-019 While rst_n=0, out_valid=0, count=0, and all stage-1 registers are 0, asynchronously and without waiting for clk.
REQ-020 A reset asserted mid-pipeline shall discard all in-flight results; none shall appear after deassertion.
REQ-021 After rst_n rises, the first input accepted is the one at the first rising clk edge with rst_n=1.

Structure
REQ-022 Package count_ones_pkg shall hold the default WIDTH, the CNT_W derivation function, and the nibble-count width constant (3).
REQ-023 One sub-module, nibble_popcount (4-bit in, 3-bit out, combinational), shall be instantiated WIDTH/4 times in stage 1.
REQ-024 The top-level count_ones shall contain only the registers, the valid chain and the parameterised adder tree.

Verification
REQ-025 vec=16'h0000, in_valid=1 -> two cycles later out_valid=1, count=0.
REQ-026 vec=16'hFFFF -> count=16 (5'b10000); vec=16'h8001 -> count=2; vec=16'hAAAA -> count=8.
REQ-027 Back-to-back 16'h0001, 16'h0003, 16'h0007 on consecutive cycles -> counts 1, 2, 3 on consecutive cycles with out_valid held high.
REQ-028 in_valid pattern 1,0,1 with vec 16'h00FF, 16'hFFFF, 16'h000F -> outputs 8, then a bubble (out_valid=0, count stays 8), then 4.
REQ-029 Assert rst_n=0 one cycle after in_valid with vec=16'hFFFF -> out_valid stays 0 and count=0 immediately; no stale 16 appears after release.
REQ-030 20000 random vectors with per-bit P(1)=6/16 -> every count matches a loop-based reference count; report ERROR on any mismatch.
